// File: rtl/al4s3b_wb_pkg.sv
// -----------------------------------------------------------------------------
// al4s3b_wb_pkg
// Shared types and constants for the Wishbone aperture controller.
//   wb_state_t          controller FSM state encoding
//   DFLT_*              default aperture geometry and base addresses
//   REG_APER_ID/QLR_APER_ID  aperture IDs (address bits above the word offset)
//   DEFAULT_READ_VALUE  read data returned for unmapped/timed-out accesses
// -----------------------------------------------------------------------------
package al4s3b_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REG_WAIT = 3'd1,
    ST_QLR_WAIT = 3'd2,
    ST_DFLT_ACK = 3'd3,
    ST_DONE     = 3'd4
  } wb_state_t;

  localparam int DFLT_APERWIDTH = 17;
  localparam int DFLT_APERSIZE  = 10;
  localparam int DFLT_ID_LSB    = DFLT_APERSIZE + 2;
  localparam int DFLT_ID_W      = DFLT_APERWIDTH - DFLT_ID_LSB;

  localparam logic [DFLT_APERWIDTH-1:0] DFLT_REG_BASE = 17'h00000;
  localparam logic [DFLT_APERWIDTH-1:0] DFLT_QLR_BASE = 17'h01000;

  localparam logic [DFLT_ID_W-1:0] REG_APER_ID = DFLT_REG_BASE[DFLT_APERWIDTH-1:DFLT_ID_LSB];
  localparam logic [DFLT_ID_W-1:0] QLR_APER_ID = DFLT_QLR_BASE[DFLT_APERWIDTH-1:DFLT_ID_LSB];

  localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC;

endpackage

// File: rtl/al4s3b_wb_aperture_ctrl_timer.sv
// -----------------------------------------------------------------------------
// wb_ack_timer
// Counts wait cycles while a target transfer is outstanding.
//   i_clk/i_rst_n  clock, async active-low reset
//   i_clr          synchronous clear (dominates i_en)
//   i_en           count this cycle
//   o_expire       high in the enabled cycle in which the count reaches
//                  CNTR_TIMEOUT, i.e. the CNTR_TIMEOUT-th waited cycle
// -----------------------------------------------------------------------------
module wb_ack_timer #(
  parameter int CNTR_WIDTH   = 3,
  parameter int CNTR_TIMEOUT = 7
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [CNTR_WIDTH-1:0] r_cnt;
  logic [CNTR_WIDTH:0]   w_cnt_nxt;

  assign w_cnt_nxt = {1'b0, r_cnt} + 1'b1;
  assign o_expire  = i_en && (w_cnt_nxt == (CNTR_WIDTH+1)'(CNTR_TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= w_cnt_nxt[CNTR_WIDTH-1:0];
  end

endmodule

// File: rtl/al4s3b_wb_aperture_ctrl.sv
// -----------------------------------------------------------------------------
// al4s3b_wb_aperture_ctrl
// Wishbone slave-side sequencer between the AHB-to-FPGA bridge and two fabric
// targets (REG register block, QLR ID/revision block). One transfer at a time;
// unmapped or timed-out accesses are acked with DEFAULT_READ_VALUE.
//   WB_CLK, WB_RSTn          clock, async active-low reset
//   WBs_ADR/CYC/STB/WE       bridge request
//   WBs_ACK, WBs_RD_DAT      registered ack / read data to bridge
//   REG_CYC, REG_ACK/RD_DAT  REG target select and response
//   QLR_CYC, QLR_ACK/RD_DAT  QLR target select and response
//   TO_CLR                   clear timeout status/count
//   TO_STS, TO_WR, TO_CNT    sticky timeout flag, WE of last timeout, sat. count
// -----------------------------------------------------------------------------
module al4s3b_wb_aperture_ctrl #(
  parameter int                   APERWIDTH                = al4s3b_wb_pkg::DFLT_APERWIDTH,
  parameter int                   APERSIZE                 = al4s3b_wb_pkg::DFLT_APERSIZE,
  parameter logic [APERWIDTH-1:0] FPGA_REG_BASE_ADDRESS    = al4s3b_wb_pkg::DFLT_REG_BASE,
  parameter logic [APERWIDTH-1:0] QL_RESERVED_BASE_ADDRESS = al4s3b_wb_pkg::DFLT_QLR_BASE,
  parameter logic [31:0]          DEFAULT_READ_VALUE       = al4s3b_wb_pkg::DEFAULT_READ_VALUE,
  parameter int                   DEFAULT_CNTR_WIDTH       = 3,
  parameter int                   DEFAULT_CNTR_TIMEOUT     = 7
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RSTn,
  input  logic [APERWIDTH-1:0] WBs_ADR,
  input  logic                 WBs_CYC,
  input  logic                 WBs_STB,
  input  logic                 WBs_WE,
  output logic                 WBs_ACK,
  output logic [31:0]          WBs_RD_DAT,
  output logic                 REG_CYC,
  input  logic                 REG_ACK,
  input  logic [31:0]          REG_RD_DAT,
  output logic                 QLR_CYC,
  input  logic                 QLR_ACK,
  input  logic [31:0]          QLR_RD_DAT,
  input  logic                 TO_CLR,
  output logic                 TO_STS,
  output logic                 TO_WR,
  output logic [7:0]           TO_CNT
);

  import al4s3b_wb_pkg::*;

  localparam int ID_LSB = APERSIZE + 2;
  localparam int ID_W   = APERWIDTH - ID_LSB;
  localparam logic [ID_W-1:0] L_REG_ID = FPGA_REG_BASE_ADDRESS[APERWIDTH-1:ID_LSB];
  localparam logic [ID_W-1:0] L_QLR_ID = QL_RESERVED_BASE_ADDRESS[APERWIDTH-1:ID_LSB];

  wb_state_t   r_state;
  logic        r_ack;
  logic [31:0] r_rd_dat;
  logic        r_to_sts;
  logic        r_to_wr;
  logic [7:0]  r_to_cnt;

  logic [ID_W-1:0] w_id;
  logic            w_in_wait;
  logic            w_tgt_ack;
  logic [31:0]     w_tgt_dat;
  logic            w_expire;

  assign w_id      = WBs_ADR[APERWIDTH-1:ID_LSB];
  assign w_in_wait = (r_state == ST_REG_WAIT) || (r_state == ST_QLR_WAIT);
  assign w_tgt_ack = (r_state == ST_REG_WAIT) ? REG_ACK    : QLR_ACK;
  assign w_tgt_dat = (r_state == ST_REG_WAIT) ? REG_RD_DAT : QLR_RD_DAT;

  // Timer is held clear outside the wait states, so every transfer starts at 0.
  // It stops counting on ack so a coincident ack never turns into a timeout.
  wb_ack_timer #(
    .CNTR_WIDTH   (DEFAULT_CNTR_WIDTH),
    .CNTR_TIMEOUT (DEFAULT_CNTR_TIMEOUT)
  ) u_timer (
    .i_clk    (WB_CLK),
    .i_rst_n  (WB_RSTn),
    .i_clr    (!w_in_wait),
    .i_en     (w_in_wait && WBs_CYC && !w_tgt_ack),
    .o_expire (w_expire)
  );

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      r_state  <= ST_IDLE;
      r_ack    <= 1'b0;
      r_rd_dat <= '0;
      r_to_sts <= 1'b0;
      r_to_wr  <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_ack <= 1'b0;
      if (TO_CLR) begin
        r_to_sts <= 1'b0;
        r_to_cnt <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (WBs_CYC && WBs_STB) begin
            if (w_id == L_REG_ID)      r_state <= ST_REG_WAIT;
            else if (w_id == L_QLR_ID) r_state <= ST_QLR_WAIT;
            else                       r_state <= ST_DFLT_ACK;
          end
        end
        ST_REG_WAIT, ST_QLR_WAIT: begin
          // Abort beats a coincident ack: the bridge has already given up.
          if (!WBs_CYC) begin
            r_state <= ST_IDLE;
          end else if (w_tgt_ack) begin
            r_ack    <= 1'b1;
            r_rd_dat <= w_tgt_dat;
            r_state  <= ST_DONE;
          end else if (w_expire) begin
            r_state <= ST_DFLT_ACK;
          end
        end
        ST_DFLT_ACK: begin
          r_ack    <= 1'b1;
          r_rd_dat <= DEFAULT_READ_VALUE;
          r_to_sts <= 1'b1;
          r_to_wr  <= WBs_WE;
          // Counting from zero when TO_CLR lands on the same edge.
          if (TO_CLR)           r_to_cnt <= 8'd1;
          else if (!(&r_to_cnt)) r_to_cnt <= r_to_cnt + 8'd1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (!WBs_STB) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Target selects decode the registered state directly so reset drops them
  // immediately and they are mutually exclusive by construction.
  assign REG_CYC    = (r_state == ST_REG_WAIT);
  assign QLR_CYC    = (r_state == ST_QLR_WAIT);
  assign WBs_ACK    = r_ack;
  assign WBs_RD_DAT = r_rd_dat;
  assign TO_STS     = r_to_sts;
  assign TO_WR      = r_to_wr;
  assign TO_CNT     = r_to_cnt;

endmodule

// File: tb/tb_al4s3b_wb_aperture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_al4s3b_wb_aperture_ctrl
// Directed transfers; a transaction-level timing model sets the expected
// outputs for each cycle and a negedge process compares them to the DUT.
// -----------------------------------------------------------------------------
module tb_al4s3b_wb_aperture_ctrl;

  localparam logic [31:0] DEF = 32'hBADFABAC;
  localparam int          TMO = 7;

  logic        WB_CLK = 1'b0;
  logic        WB_RSTn = 1'b0;
  logic [16:0] WBs_ADR = '0;
  logic        WBs_CYC = 1'b0, WBs_STB = 1'b0, WBs_WE = 1'b0;
  logic        WBs_ACK;
  logic [31:0] WBs_RD_DAT;
  logic        REG_CYC, QLR_CYC;
  logic        REG_ACK = 1'b0, QLR_ACK = 1'b0;
  logic [31:0] REG_RD_DAT = '0, QLR_RD_DAT = '0;
  logic        TO_CLR = 1'b0;
  logic        TO_STS, TO_WR;
  logic [7:0]  TO_CNT;

  al4s3b_wb_aperture_ctrl dut (
    .WB_CLK     (WB_CLK),
    .WB_RSTn    (WB_RSTn),
    .WBs_ADR    (WBs_ADR),
    .WBs_CYC    (WBs_CYC),
    .WBs_STB    (WBs_STB),
    .WBs_WE     (WBs_WE),
    .WBs_ACK    (WBs_ACK),
    .WBs_RD_DAT (WBs_RD_DAT),
    .REG_CYC    (REG_CYC),
    .REG_ACK    (REG_ACK),
    .REG_RD_DAT (REG_RD_DAT),
    .QLR_CYC    (QLR_CYC),
    .QLR_ACK    (QLR_ACK),
    .QLR_RD_DAT (QLR_RD_DAT),
    .TO_CLR     (TO_CLR),
    .TO_STS     (TO_STS),
    .TO_WR      (TO_WR),
    .TO_CNT     (TO_CNT)
  );

  always #5 WB_CLK = ~WB_CLK;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected per-cycle outputs and model state.
  bit          chk_en  = 1'b1;
  bit          exp_ack = 1'b0, exp_reg = 1'b0, exp_qlr = 1'b0;
  logic [31:0] m_rd    = '0;
  bit          m_sts   = 1'b0, m_wr = 1'b0;
  logic [7:0]  m_cnt   = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge WB_CLK) begin
    if (chk_en) begin
      chk("WBs_ACK",    32'(WBs_ACK), 32'(exp_ack));
      chk("REG_CYC",    32'(REG_CYC), 32'(exp_reg));
      chk("QLR_CYC",    32'(QLR_CYC), 32'(exp_qlr));
      chk("WBs_RD_DAT", WBs_RD_DAT,   m_rd);
      chk("TO_STS",     32'(TO_STS),  32'(m_sts));
      chk("TO_WR",      32'(TO_WR),   32'(m_wr));
      chk("TO_CNT",     32'(TO_CNT),  32'(m_cnt));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge WB_CLK); #1;
      WBs_CYC = 1'b0; WBs_STB = 1'b0; REG_ACK = 1'b0; QLR_ACK = 1'b0;
      exp_ack = 1'b0; exp_reg = 1'b0; exp_qlr = 1'b0;
    end
  endtask

  // One bridge transfer. Cycle 0 is the first cycle STB is high.
  // ack_k: cycle in which the target raises ACK (0 = never).
  // abort_at: cycle in which the bridge drops CYC (0 = no abort).
  // clr_dflt: pulse TO_CLR in the default-ack cycle.
  // obs: first cycle WBs_ACK was seen high, -1 if never.
  task automatic xfer(input logic [16:0] adr, input logic we, input int ack_k,
                      input logic [31:0] dat, input int abort_at, input bit clr_dflt,
                      output int obs);
    int  tgt, last_wait, ack_cyc, last;
    bit  real_ack, tmo, abrt;
    logic [4:0] id;
    id  = adr[16:12];
    tgt = (id == 5'd0) ? 1 : (id == 5'd1) ? 2 : 0;
    if (tgt == 0) begin
      real_ack = 0; tmo = 1; last_wait = 0; ack_cyc = 2;
    end else if (ack_k >= 1 && ack_k <= TMO) begin
      real_ack = 1; tmo = 0; last_wait = ack_k; ack_cyc = ack_k + 1;
    end else begin
      real_ack = 0; tmo = 1; last_wait = TMO; ack_cyc = TMO + 2;
    end
    abrt = (tgt != 0) && (abort_at >= 1) && (abort_at <= last_wait);
    if (abrt) last_wait = abort_at;
    last = abrt ? abort_at + 1 : ack_cyc + 1;
    obs  = -1;
    for (int c = 0; c <= last; c++) begin
      @(posedge WB_CLK); #1;
      WBs_ADR    = adr;
      WBs_WE     = we;
      WBs_CYC    = abrt ? (c < abort_at) : (c <= ack_cyc);
      WBs_STB    = WBs_CYC;
      REG_ACK    = (tgt == 1) && (c == ack_k);
      QLR_ACK    = (tgt == 2) && (c == ack_k);
      REG_RD_DAT = (c == ack_k) ? dat : ~dat;
      QLR_RD_DAT = (c == ack_k) ? dat : ~dat;
      TO_CLR     = clr_dflt && tmo && (c == ack_cyc - 1);
      exp_reg    = (tgt == 1) && (c >= 1) && (c <= last_wait);
      exp_qlr    = (tgt == 2) && (c >= 1) && (c <= last_wait);
      exp_ack    = !abrt && (c == ack_cyc);
      if (!abrt && c == ack_cyc) begin
        m_rd = real_ack ? dat : DEF;
        if (tmo) begin
          m_sts = 1'b1;
          m_wr  = we;
          if (clr_dflt)           m_cnt = 8'd1;
          else if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
      end
      @(negedge WB_CLK);
      if (WBs_ACK && obs < 0) obs = c;
    end
    TO_CLR = 1'b0; REG_ACK = 1'b0; QLR_ACK = 1'b0; WBs_WE = 1'b0;
  endtask

  int o;

  initial begin
    idle(3);
    WB_RSTn = 1'b1;
    idle(2);

    // REG read, ack in cycle 2 -> WBs_ACK cycle 3
    xfer(17'h00004, 1'b0, 2, 32'h1234_5678, 0, 0, o);
    chk("t1_ack_cycle", 32'(o), 32'd3);
    chk("t1_rd_dat",    WBs_RD_DAT, 32'h1234_5678);
    chk("t1_to_sts",    32'(TO_STS), 32'd0);
    idle(1);

    // QLR read, ack 3 cycles after QLR_CYC rises
    xfer(17'h011F8, 1'b0, 4, 32'hCAFE_0001, 0, 0, o);
    chk("t2_ack_cycle", 32'(o), 32'd5);
    chk("t2_rd_dat",    WBs_RD_DAT, 32'hCAFE_0001);
    idle(1);

    // Unmapped write
    xfer(17'h02000, 1'b1, 0, 32'h0, 0, 0, o);
    chk("t3_ack_cycle", 32'(o), 32'd2);
    chk("t3_rd_dat",    WBs_RD_DAT, 32'hBADFABAC);
    chk("t3_to_cnt",    32'(TO_CNT), 32'd1);
    chk("t3_to_wr",     32'(TO_WR), 32'd1);
    idle(1);

    // REG timeout, then ack coincident with expiry
    xfer(17'h00008, 1'b0, 0, 32'h0, 0, 0, o);
    chk("t4_tmo_cycle", 32'(o), 32'd9);
    chk("t4_tmo_cnt",   32'(TO_CNT), 32'd2);
    chk("t4_tmo_wr",    32'(TO_WR), 32'd0);
    idle(1);
    xfer(17'h00008, 1'b0, 7, 32'h5A5A_0007, 0, 0, o);
    chk("t4_edge_cycle", 32'(o), 32'd8);
    chk("t4_edge_dat",   WBs_RD_DAT, 32'h5A5A_0007);
    chk("t4_edge_cnt",   32'(TO_CNT), 32'd2);
    idle(1);

    // Standalone clear
    @(posedge WB_CLK); #1; TO_CLR = 1'b1;
    @(posedge WB_CLK); #1; TO_CLR = 1'b0; m_sts = 1'b0; m_cnt = '0;
    @(negedge WB_CLK);
    chk("clr_cnt", 32'(TO_CNT), 32'd0);
    chk("clr_sts", 32'(TO_STS), 32'd0);

    // Abort in REG_WAIT cycle 3, fast QLR ack, QLR timeout
    xfer(17'h00010, 1'b0, 0, 32'h0, 3, 0, o);
    chk("t6_abort_noack", 32'(o), 32'hFFFF_FFFF);
    chk("t6_abort_cnt",   32'(TO_CNT), 32'd0);
    idle(1);
    xfer(17'h01004, 1'b0, 1, 32'h0000_0A11, 0, 0, o);
    chk("qlr_fast_cycle", 32'(o), 32'd2);
    idle(1);
    xfer(17'h01004, 1'b0, 0, 32'h0, 0, 0, o);
    chk("qlr_tmo_cycle", 32'(o), 32'd9);
    chk("qlr_tmo_cnt",   32'(TO_CNT), 32'd1);

    // Saturation, then TO_CLR coincident with the next default ack
    for (int i = 0; i < 300; i++)
      xfer(17'h04000 + 17'(i * 4), 1'(i & 1), 0, 32'h0, 0, 0, o);
    chk("t5_sat", 32'(TO_CNT), 32'hFF);
    xfer(17'h1FFFC, 1'b0, 0, 32'h0, 0, 1, o);
    chk("t5_clr_cnt", 32'(TO_CNT), 32'd1);
    chk("t5_clr_sts", 32'(TO_STS), 32'd1);
    idle(1);

    // Async reset in the middle of QLR_WAIT
    @(posedge WB_CLK); #1;
    WBs_ADR = 17'h01000; WBs_CYC = 1'b1; WBs_STB = 1'b1;
    @(posedge WB_CLK); #1; exp_qlr = 1'b1;
    @(negedge WB_CLK); #1;
    WB_RSTn = 1'b0;
    #1;
    chk("rst_qlr_cyc", 32'(QLR_CYC), 32'd0);
    chk("rst_ack",     32'(WBs_ACK), 32'd0);
    chk("rst_rd_dat",  WBs_RD_DAT,   32'd0);
    chk("rst_to_cnt",  32'(TO_CNT),  32'd0);
    chk("rst_to_sts",  32'(TO_STS),  32'd0);
    exp_qlr = 1'b0; m_rd = '0; m_sts = 1'b0; m_wr = 1'b0; m_cnt = '0;
    WBs_CYC = 1'b0; WBs_STB = 1'b0;
    idle(2);
    WB_RSTn = 1'b1;
    idle(2);
    xfer(17'h00020, 1'b0, 3, 32'h0BAD_BEEF, 0, 0, o);
    chk("post_rst_cycle", 32'(o), 32'd4);
    idle(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
